// File: rtl/mul_sched.sv
// Round-robin scheduler in front of an iterative shift-add multiplier.
// Two requesters share the engine; one partial product is accumulated per clock.
module mul_sched #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [2*N-1:0]   resp_y,
    input  logic             resp_ready,
    output logic             busy
);

    localparam int unsigned W    = 2 * N;
    localparam int unsigned CT_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      a_r;
    logic [N-1:0]      b_r;
    logic [W-1:0]      acc;
    logic [W-1:0]      pp;
    logic [CT_W-1:0]   ct;
    logic              id_r;
    logic              last_grant;
    logic              grant_any;
    logic              grant_id;
    logic              accept;
    logic              ct_last;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        accept     = (state == IDLE) & grant_any;
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
    end

    always_comb begin
        ct_last = (ct == CT_W'(N - 1));
        pp      = a_r[ct] ? (W'(b_r) << ct) : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (ct_last)    state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch and shift-add accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            ct         <= '0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r        <= grant_id ? req1_a : req0_a;
                        b_r        <= grant_id ? req1_b : req0_b;
                        id_r       <= grant_id;
                        last_grant <= grant_id;
                        acc        <= '0;
                        ct         <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + pp;
                    ct  <= ct + CT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == DONE);
    assign resp_y     = resp_valid ? acc : '0;
    assign resp_id    = resp_valid & id_r;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed scenarios plus randomized
// operations checked against a product/round-robin reference model.
module tb_mul_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         resp_valid;
    logic         resp_id;
    logic [W-1:0] resp_y;
    logic         resp_ready;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_last;

    mul_sched #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: round-robin pick between two valid requesters.
    function automatic bit mdl_pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    function automatic logic [W-1:0] mdl_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return W'(int'(a) * int'(b));
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_last = 1'b1;
    endtask

    // Called at the negedge after the accept edge; counts edges until resp_valid.
    task automatic wait_resp(input int budget, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b1;
        while (!resp_valid) begin
            if (edges >= budget) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({resp_valid, resp_id, busy, req0_ready, req1_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 00000", {resp_valid, resp_id, busy, req0_ready, req1_ready});
        end
        n_tests++;
        if (resp_y !== '0) begin
            n_fail++;
            $display("FAIL reset_y: got %0d exp 0", resp_y);
        end
        rst = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_single();
        int edges;
        int busy_cnt;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        resp_ready = 1'b1;
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b exp 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!resp_valid && edges < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        if (busy) busy_cnt++;
        n_tests++;
        if (edges != 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d edges exp 4", edges);
        end
        n_tests++;
        if (resp_y !== 8'd15 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got y=%0d id=%0d exp y=15 id=0", resp_y, resp_id);
        end
        @(negedge clk);
        n_tests++;
        if (busy_cnt != 5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %0d cycles (busy now %b) exp 5 (0)", busy_cnt, busy);
        end
        resp_ready = 1'b0;
        mdl_last = 1'b0;
    endtask

    task automatic test_tie();
        int edges;
        bit ok;
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd7;  req0_b = 4'd9;
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
        resp_ready = 1'b1;
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_first_grant: got %b exp 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp(10, edges, ok);
        n_tests++;
        if (!ok || resp_y !== 8'd63 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first_result: got ok=%0d y=%0d id=%0d exp y=63 id=0", ok, resp_y, resp_id);
        end
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_ready_in_done: got %b exp 0", req1_ready);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_second_accept: got busy=%b ready=%b exp busy=0 ready=1", busy, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_second_busy: got %b exp 1", busy);
        end
        wait_resp(10, edges, ok);
        n_tests++;
        if (!ok || resp_y !== 8'd225 || resp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_second_result: got ok=%0d y=%0d id=%0d exp y=225 id=1", ok, resp_y, resp_id);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_fairness();
        int n_resp;
        int bad_ready;
        bit exp_id;
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd7;
        resp_ready = 1'b1;
        n_resp = 0;
        bad_ready = 0;
        for (int cyc = 0; cyc < 80 && n_resp < 6; cyc++) begin
            @(negedge clk);
            if (busy && (req0_ready || req1_ready)) bad_ready++;
            if (resp_valid) begin
                exp_id = mdl_pick(1'b1, 1'b1, mdl_last);
                mdl_last = exp_id;
                n_tests++;
                if (resp_id !== exp_id || resp_y !== (exp_id ? 8'd35 : 8'd6)) begin
                    n_fail++;
                    $display("FAIL fair_resp%0d: got id=%0d y=%0d exp id=%0d y=%0d",
                             n_resp, resp_id, resp_y, exp_id, exp_id ? 35 : 6);
                end
                n_resp++;
                if (n_resp == 6) idle_inputs();
            end
        end
        n_tests++;
        if (n_resp != 6) begin
            n_fail++;
            $display("FAIL fair_count: got %0d responses exp 6", n_resp);
        end
        n_tests++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL fair_ready_busy: got %0d cycles with ready while busy exp 0", bad_ready);
        end
        idle_inputs();
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        bit ok;
        req1_valid = 1'b1; req1_a = 4'd11; req1_b = 4'd13;
        resp_ready = 1'b0;
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_grant: got %b exp 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(10, edges, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout: got no resp_valid exp resp_valid");
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (resp_valid !== 1'b1 || resp_y !== 8'd143 || resp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b y=%0d id=%b r0=%b r1=%b exp v=1 y=143 id=1 r0=0 r1=0",
                         i, resp_valid, resp_y, resp_id, req0_ready, req1_ready);
            end
        end
        idle_inputs();
        resp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_y !== '0 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b v=%b y=%0d id=%b exp all 0", busy, resp_valid, resp_y, resp_id);
        end
        resp_ready = 1'b0;
        mdl_last = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int edges;
        int seen;
        bit ok;
        req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd11;
        resp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_last = 1'b1;
        n_tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_y !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: got v=%b busy=%b y=%0d exp all 0", resp_valid, busy, resp_y);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_resp: got %0d response cycles exp 0", seen);
        end
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd5;
        #1;
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_tie: got %b exp 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        idle_inputs();
        wait_resp(10, edges, ok);
        n_tests++;
        if (!ok || resp_y !== 8'd6 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_tie_result: got ok=%0d y=%0d id=%0d exp y=6 id=0", ok, resp_y, resp_id);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        mdl_last = 1'b0;
    endtask

    task automatic test_boundary();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic [W-1:0] exp_y;
        int edges;
        bit ok;
        ta = '{4'd0, 4'd15, 4'd1, 4'd15};
        tb = '{4'd15, 4'd0, 4'd1, 4'd15};
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_y = mdl_mul(ta[i], tb[i]);
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i];
            @(negedge clk);
            req0_valid = 1'b0;
            req0_a = N'($urandom);
            req0_b = N'($urandom);
            wait_resp(10, edges, ok);
            n_tests++;
            if (!ok || resp_y !== exp_y || resp_id !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary_%0dx%0d: got ok=%0d y=%0d id=%0d exp y=%0d id=0",
                         ta[i], tb[i], ok, resp_y, resp_id, exp_y);
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        mdl_last = 1'b0;
    endtask

    task automatic test_random();
        bit v0;
        bit v1;
        bit exp_id;
        logic [W-1:0] exp_y;
        int edges;
        int hold;
        bit ok;
        for (int k = 0; k < 24; k++) begin
            do begin
                v0 = 1'($urandom);
                v1 = 1'($urandom);
            end while (!v0 && !v1);
            req0_valid = v0; req0_a = N'($urandom); req0_b = N'($urandom);
            req1_valid = v1; req1_a = N'($urandom); req1_b = N'($urandom);
            exp_id = mdl_pick(v0, v1, mdl_last);
            exp_y  = exp_id ? mdl_mul(req1_a, req1_b) : mdl_mul(req0_a, req0_b);
            resp_ready = 1'b0;
            #1;
            n_tests++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rand%0d_grant: got %b exp %b", k, {req1_ready, req0_ready},
                         exp_id ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            mdl_last = exp_id;
            req0_valid = 1'($urandom); req0_a = N'($urandom); req0_b = N'($urandom);
            req1_valid = 1'($urandom); req1_a = N'($urandom); req1_b = N'($urandom);
            wait_resp(10, edges, ok);
            n_tests++;
            if (!ok || edges != 4 || resp_y !== exp_y || resp_id !== exp_id) begin
                n_fail++;
                $display("FAIL rand%0d_result: got ok=%0d edges=%0d y=%0d id=%0d exp edges=4 y=%0d id=%0d",
                         k, ok, edges, resp_y, resp_id, exp_y, exp_id);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            n_tests++;
            if (resp_valid !== 1'b1 || resp_y !== exp_y || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_hold: got v=%b y=%0d r0=%b r1=%b exp v=1 y=%0d r0=0 r1=0",
                         k, resp_valid, resp_y, req0_ready, req1_ready, exp_y);
            end
            idle_inputs();
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            n_tests++;
            if (busy !== 1'b0 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_release: got busy=%b v=%b exp 0 0", k, busy, resp_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        idle_inputs();
        mdl_last = 1'b1;
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid_run();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
